// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, the halt instruction word and the
// fetch sequencer state encoding.
package cpu_pkg;

    localparam int RegWidth = 16;

    localparam logic [RegWidth-1:0] HaltInstr = 16'h0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for an instruction that returned from memory while the
// IF/ID register was still occupied by an instruction ID had not accepted.
module fetch_skid_buffer
    import cpu_pkg::*;
#(
    parameter int Width = RegWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             unload,
    input  logic             flush,
    input  logic [Width-1:0] instr_in,
    input  logic [Width-1:0] pc_in,
    output logic             valid,
    output logic [Width-1:0] instr,
    output logic [Width-1:0] pc
);

    logic             valid_q, valid_d;
    logic [Width-1:0] instr_q, instr_d;
    logic [Width-1:0] pc_q, pc_d;

    // A load in the same cycle as an unload refills the slot with the newer word.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: issues instruction reads, owns the IF/ID register and
// reacts to jump/halt decode from IF and branch redirects from EX.
module fetch_sequencer #(
    parameter int                  RegWidth    = cpu_pkg::RegWidth,
    parameter logic [RegWidth-1:0] ResetVector = '0
) (
    input  logic                Clk,
    input  logic                Reset,
    output logic                ImemReq,
    output logic [RegWidth-1:0] ImemAddr,
    input  logic                ImemValid,
    input  logic [RegWidth-1:0] ImemData,
    input  logic                Stall,
    input  logic                TakeJump,
    input  logic [RegWidth-1:0] JumpAddress,
    input  logic                Halt,
    input  logic                BranchTaken,
    input  logic [RegWidth-1:0] BranchTarget,
    output logic [RegWidth-1:0] InstrOut,
    output logic [RegWidth-1:0] PCOut,
    output logic                InstrValid,
    output logic                Halted
);
    import cpu_pkg::*;

    fetch_state_t        state_q, state_d;
    logic                halt_after_q, halt_after_d;
    logic [RegWidth-1:0] pc_q, pc_d;
    logic [RegWidth-1:0] instr_q, instr_d;
    logic [RegWidth-1:0] pc_out_q, pc_out_d;
    logic                valid_q, valid_d;

    logic                skid_valid;
    logic [RegWidth-1:0] skid_instr;
    logic [RegWidth-1:0] skid_pc;
    logic                skid_load, skid_unload, skid_flush;

    logic                consume, do_jump, do_halt, redirect;
    logic                live_rsp, ifid_free, still_out, skid_empty_next, issue;
    logic [RegWidth-1:0] rsp_pc;

    fetch_skid_buffer #(
        .Width(RegWidth)
    ) u_skid (
        .clk     (Clk),
        .reset   (Reset),
        .load    (skid_load),
        .unload  (skid_unload),
        .flush   (skid_flush),
        .instr_in(ImemData),
        .pc_in   (rsp_pc),
        .valid   (skid_valid),
        .instr   (skid_instr),
        .pc      (skid_pc)
    );

    assign consume   = valid_q & ~Stall;
    assign do_halt   = Halt & consume & ~BranchTaken;
    assign do_jump   = TakeJump & consume & ~BranchTaken & ~Halt;
    assign redirect  = BranchTaken | do_halt | do_jump;
    assign live_rsp  = ImemValid & (state_q == WAIT);
    assign ifid_free = ~valid_q | consume;
    assign still_out = ~ImemValid & ((state_q == WAIT) | (state_q == DRAIN));
    // PC only moves past an issued address, so the live response is always pc_q - 1.
    assign rsp_pc    = pc_q - RegWidth'(1);

    always_comb begin
        instr_d         = instr_q;
        pc_out_d        = pc_out_q;
        valid_d         = valid_q;
        skid_load       = 1'b0;
        skid_unload     = 1'b0;
        skid_flush      = 1'b0;
        skid_empty_next = 1'b1;
        if (redirect) begin
            valid_d    = 1'b0;
            skid_flush = 1'b1;
        end else if (skid_valid) begin
            if (ifid_free) begin
                instr_d         = skid_instr;
                pc_out_d        = skid_pc;
                valid_d         = 1'b1;
                skid_unload     = 1'b1;
                skid_load       = live_rsp;
                skid_empty_next = ~live_rsp;
            end else begin
                skid_empty_next = 1'b0;
            end
        end else if (live_rsp) begin
            if (ifid_free) begin
                instr_d  = ImemData;
                pc_out_d = rsp_pc;
                valid_d  = 1'b1;
            end else begin
                skid_load       = 1'b1;
                skid_empty_next = 1'b0;
            end
        end else if (consume) begin
            valid_d = 1'b0;
        end
        issue = ~Reset & ~redirect & skid_empty_next & ((state_q == IDLE) | live_rsp);
    end

    // Redirects leave any in-flight read to be drained; HaltAfter decides where DRAIN lands.
    always_comb begin
        state_d      = state_q;
        halt_after_d = halt_after_q;
        pc_d         = pc_q;
        if (BranchTaken) begin
            pc_d         = BranchTarget;
            halt_after_d = 1'b0;
            state_d      = still_out ? DRAIN : IDLE;
        end else if (do_jump | do_halt) begin
            if (do_jump) begin
                pc_d = JumpAddress;
            end
            if (still_out) begin
                state_d      = DRAIN;
                halt_after_d = do_halt;
            end else begin
                state_d = do_halt ? HALTED : IDLE;
            end
        end else begin
            if (issue) begin
                pc_d = pc_q + RegWidth'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (ImemValid) begin
                        state_d = issue ? WAIT : IDLE;
                    end
                end
                DRAIN: begin
                    if (ImemValid) begin
                        state_d      = halt_after_q ? HALTED : IDLE;
                        halt_after_d = 1'b0;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            halt_after_q <= 1'b0;
            pc_q         <= ResetVector;
            instr_q      <= '0;
            pc_out_q     <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            halt_after_q <= halt_after_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
        end
    end

    assign ImemReq    = issue;
    assign ImemAddr   = pc_q;
    assign InstrOut   = instr_q;
    assign PCOut      = pc_out_q;
    assign InstrValid = valid_q;
    assign Halted     = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then randomized traffic, all checked
// against a transaction-level model (instruction FIFO plus one outstanding read).
`timescale 1ns/1ps
module tb_fetch_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ImemReq;
    logic [15:0] ImemAddr;
    logic        ImemValid = 1'b0;
    logic [15:0] ImemData = '0;
    logic        Stall = 1'b0;
    logic        TakeJump = 1'b0;
    logic [15:0] JumpAddress = '0;
    logic        Halt = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [15:0] BranchTarget = '0;
    logic [15:0] InstrOut;
    logic [15:0] PCOut;
    logic        InstrValid;
    logic        Halted;

    always #5 Clk = ~Clk;

    fetch_sequencer #(
        .RegWidth   (16),
        .ResetVector(16'h0000)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemValid   (ImemValid),
        .ImemData    (ImemData),
        .Stall       (Stall),
        .TakeJump    (TakeJump),
        .JumpAddress (JumpAddress),
        .Halt        (Halt),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .InstrOut    (InstrOut),
        .PCOut       (PCOut),
        .InstrValid  (InstrValid),
        .Halted      (Halted)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } entry_t;

    entry_t      mq[$];
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_req_addr = 16'h0000;
    bit          m_outst = 0;
    bit          m_live = 0;
    bit          m_halt_after = 0;
    bit          m_halted = 0;

    bit          mem_pend = 0;
    int          mem_rem = 0;
    int          mem_lat = 1;
    bit          mem_rand = 0;
    logic [15:0] mem_addr = '0;
    logic [15:0] halt_addr = 16'hFFFF;
    bit          inject_stale = 0;

    logic        obs_req, obs_valid, obs_halted;
    logic [15:0] obs_addr, obs_pc, obs_instr;

    function automatic logic [15:0] memData(input logic [15:0] a);
        return (a == halt_addr) ? 16'h0000 : a + 16'h9010;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_pc         = 16'h0000;
        m_outst      = 0;
        m_live       = 0;
        m_halt_after = 0;
        m_halted     = 0;
    endtask

    // One clock cycle: drive inputs, predict and compare at the falling edge, advance the model.
    task automatic applyStimulus(input bit rst, input bit stl, input bit tj, input logic [15:0] ja,
                                 input bit br, input logic [15:0] bt);
        entry_t head;
        bit     mv, consume, do_halt, do_jump, redirect, rsp, live_rsp, exp_req;
        int     n;
        ImemValid = 1'b0;
        ImemData  = '0;
        if (inject_stale) begin
            ImemValid    = 1'b1;
            ImemData     = 16'hDEAD;
            inject_stale = 0;
        end else if (mem_pend) begin
            mem_rem--;
            if (mem_rem == 0) begin
                ImemValid = 1'b1;
                ImemData  = memData(mem_addr);
                mem_pend  = 0;
            end
        end
        mv   = (mq.size() > 0);
        head = mv ? mq[0] : '0;
        Reset        = rst;
        Stall        = stl;
        Halt         = mv && (head.instr == 16'h0000);
        TakeJump     = tj && !Halt;
        JumpAddress  = ja;
        BranchTaken  = br;
        BranchTarget = bt;
        consume  = mv && !stl;
        do_halt  = consume && Halt && !br;
        do_jump  = consume && TakeJump && !br;
        redirect = br || do_halt || do_jump;
        rsp      = ImemValid && m_outst;
        live_rsp = rsp && m_live;
        n        = mq.size() - int'(consume) + int'(live_rsp);
        exp_req  = !rst && !m_halted && (!m_outst || live_rsp) && (n <= 1) && !redirect;

        @(negedge Clk);
        obs_req    = ImemReq;
        obs_addr   = ImemAddr;
        obs_valid  = InstrValid;
        obs_pc     = PCOut;
        obs_instr  = InstrOut;
        obs_halted = Halted;
        checkOutput("imem_req", 16'(ImemReq), 16'(exp_req));
        if (exp_req) checkOutput("imem_addr", ImemAddr, m_pc);
        checkOutput("instr_valid", 16'(InstrValid), 16'(mv));
        if (mv) begin
            checkOutput("instr_out", InstrOut, head.instr);
            checkOutput("pc_out", PCOut, head.pc);
        end
        checkOutput("halted", 16'(Halted), 16'(m_halted));
        if (Reset) begin
            mem_pend = 0;
        end else if (ImemReq) begin
            mem_pend = 1;
            mem_addr = ImemAddr;
            mem_rem  = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
        end

        @(posedge Clk);
        if (rst) begin
            modelReset();
        end else if (br) begin
            mq.delete();
            m_pc         = bt;
            m_halt_after = 0;
            m_halted     = 0;
            if (m_outst && !rsp) m_live = 0;
            else m_outst = 0;
        end else if (do_halt || do_jump) begin
            mq.delete();
            if (do_jump) m_pc = ja;
            if (m_outst && !rsp) begin
                m_live       = 0;
                m_halt_after = do_halt;
            end else begin
                m_outst  = 0;
                m_halted = do_halt;
            end
        end else begin
            if (consume) void'(mq.pop_front());
            if (live_rsp) mq.push_back(entry_t'{instr: ImemData, pc: m_req_addr});
            if (rsp && !m_live) begin
                m_halted     = m_halt_after;
                m_halt_after = 0;
            end
            if (rsp) m_outst = 0;
            if (exp_req) begin
                m_outst    = 1;
                m_live     = 1;
                m_req_addr = m_pc;
                m_pc       = m_pc + 16'h0001;
            end
        end
        #1;
    endtask

    task automatic runIdle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(0, 0, 0, '0, 0, '0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit found;
        Reset = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        modelReset();

        // Reset values, then a 1-cycle memory stream from the reset vector.
        applyStimulus(1, 0, 0, '0, 0, '0);
        checkOutput("rst_instr_out", obs_instr, 16'h0000);
        checkOutput("rst_pc_out", obs_pc, 16'h0000);
        checkOutput("rst_req", 16'(obs_req), 16'h0000);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 0, 0, '0, 0, '0);
            if (k < 4) begin
                checkOutput("t1_req", 16'(obs_req), 16'h0001);
                checkOutput("t1_addr", obs_addr, 16'(k));
            end
            if (k >= 2) begin
                checkOutput("t1_valid", 16'(obs_valid), 16'h0001);
                checkOutput("t1_pc", obs_pc, 16'(k - 2));
                checkOutput("t1_instr", obs_instr, 16'(k - 2) + 16'h9010);
            end
        end

        // Jump at PCOut 8 to 0x0020.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq.size() > 0 && mq[0].pc == 16'h0008) begin
                applyStimulus(0, 0, 1, 16'h0020, 0, '0);
                found = 1;
            end else begin
                applyStimulus(0, 0, 0, '0, 0, '0);
            end
        end
        checkOutput("t2_reached", 16'(found), 16'h0001);
        applyStimulus(0, 0, 0, '0, 0, '0);
        checkOutput("t2_bubble", 16'(obs_valid), 16'h0000);
        checkOutput("t2_req", 16'(obs_req), 16'h0001);
        checkOutput("t2_addr", obs_addr, 16'h0020);
        runIdle(1);
        applyStimulus(0, 0, 0, '0, 0, '0);
        checkOutput("t2_valid", 16'(obs_valid), 16'h0001);
        checkOutput("t2_pc", obs_pc, 16'h0020);

        // Stall four cycles while PCOut is 5.
        applyStimulus(0, 0, 0, '0, 1, 16'h0000);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq.size() > 0 && mq[0].pc == 16'h0005) found = 1;
            else applyStimulus(0, 0, 0, '0, 0, '0);
        end
        checkOutput("t3_reached", 16'(found), 16'h0001);
        for (int s = 0; s < 4; s++) begin
            applyStimulus(0, 1, 0, '0, 0, '0);
            checkOutput("t3_hold_pc", obs_pc, 16'h0005);
            checkOutput("t3_no_req", 16'(obs_req), 16'h0000);
        end
        applyStimulus(0, 0, 0, '0, 0, '0);
        checkOutput("t3_release_pc", obs_pc, 16'h0005);
        applyStimulus(0, 0, 0, '0, 0, '0);
        checkOutput("t3_pc6", obs_pc, 16'h0006);
        applyStimulus(0, 0, 0, '0, 0, '0);
        checkOutput("t3_pc7", obs_pc, 16'h0007);
        checkOutput("t3_valid7", 16'(obs_valid), 16'h0001);

        // Halt word at address 3 with 2-cycle memory so a read is outstanding.
        halt_addr = 16'h0003;
        mem_lat   = 2;
        applyStimulus(0, 0, 0, '0, 1, 16'h0000);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (m_halted) found = 1;
            else applyStimulus(0, 0, 0, '0, 0, '0);
        end
        checkOutput("t4_reached", 16'(found), 16'h0001);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0, '0, 0, '0);
            checkOutput("t4_halted", 16'(obs_halted), 16'h0001);
            checkOutput("t4_no_req", 16'(obs_req), 16'h0000);
        end
        halt_addr = 16'hFFFF;
        mem_lat   = 1;
        applyStimulus(0, 0, 0, '0, 1, 16'h0040);
        applyStimulus(0, 0, 0, '0, 0, '0);
        checkOutput("t4_unhalted", 16'(obs_halted), 16'h0000);
        checkOutput("t4_req", 16'(obs_req), 16'h0001);
        checkOutput("t4_addr", obs_addr, 16'h0040);

        // Branch and jump together under Stall: branch wins and IF/ID flushes.
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (mq.size() > 0) found = 1;
            else applyStimulus(0, 0, 0, '0, 0, '0);
        end
        checkOutput("t5_reached", 16'(found), 16'h0001);
        applyStimulus(0, 1, 1, 16'h0030, 1, 16'h0050);
        applyStimulus(0, 0, 0, '0, 0, '0);
        checkOutput("t5_flushed", 16'(obs_valid), 16'h0000);
        checkOutput("t5_req", 16'(obs_req), 16'h0001);
        checkOutput("t5_addr", obs_addr, 16'h0050);

        // 3-cycle memory, Reset mid-WAIT, stale response after Reset falls.
        mem_lat = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(0, 0, 0, '0, 0, '0);
            if (m_outst && mem_pend && mem_rem >= 2) found = 1;
        end
        checkOutput("t6_in_wait", 16'(found), 16'h0001);
        applyStimulus(1, 0, 0, '0, 0, '0);
        checkOutput("t6_rst_req", 16'(obs_req), 16'h0000);
        applyStimulus(1, 0, 0, '0, 0, '0);
        checkOutput("t6_rst_valid", 16'(obs_valid), 16'h0000);
        checkOutput("t6_rst_instr", obs_instr, 16'h0000);
        checkOutput("t6_rst_pc", obs_pc, 16'h0000);
        checkOutput("t6_rst_halted", 16'(obs_halted), 16'h0000);
        inject_stale = 1;
        applyStimulus(0, 0, 0, '0, 0, '0);
        checkOutput("t6_restart_req", 16'(obs_req), 16'h0001);
        checkOutput("t6_restart_addr", obs_addr, 16'h0000);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            applyStimulus(0, 0, 0, '0, 0, '0);
            if (obs_valid) begin
                found = 1;
                checkOutput("t6_first_pc", obs_pc, 16'h0000);
                checkOutput("t6_first_instr", obs_instr, 16'h9010);
            end
        end
        checkOutput("t6_first_valid", 16'(found), 16'h0001);

        // Randomized traffic with variable memory latency.
        mem_rand  = 1;
        halt_addr = 16'h0017;
        for (int c = 0; c < 1500; c++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 9) < 3,
                          $urandom_range(0, 9) == 0,
                          16'($urandom_range(0, 63)),
                          $urandom_range(0, 49) == 0,
                          16'($urandom_range(0, 63)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

- Produces the PC stream for the IF stage and issues instruction-memory reads.
- Owns the IF/ID instruction register, whose `InstrOut`/`PCOut` feed the jump-decode logic.
- Acts on the resulting `TakeJump`/`JumpAddress`/`Halt` (same IF stage) and on `BranchTaken`/`BranchTarget` from EX.
- Handles variable-latency memory, downstream stall, wrong-path squash and halt.

## Interface
- `RegWidth`, 16, instruction and PC width (word-addressed PC).
- `ResetVector`, 16'h0000, first fetch address after reset.
- `Clk` input 1: rising-edge clock.
- `Reset` input 1: synchronous, active-high.
- `ImemReq` output 1: read request, one cycle per request.
- `ImemAddr` output RegWidth: read address, valid with `ImemReq`.
- `ImemValid` input 1: read data valid, at least 1 cycle after request.
- `ImemData` input RegWidth: instruction word.
- `Stall` input 1: ID not accepting; hold IF/ID.
- `TakeJump` input 1: from jump decode, evaluated on `InstrOut`/`PCOut`.
- `JumpAddress` input RegWidth: jump target.
- `Halt` input 1: `InstrOut` is the halt encoding 16'h0000.
- `BranchTaken` input 1: EX redirect, highest priority.
- `BranchTarget` input RegWidth: EX target.
- `InstrOut` output RegWidth: IF/ID instruction.
- `PCOut` output RegWidth: address of `InstrOut`.
- `InstrValid` output 1: IF/ID holds a live instruction.
- `Halted` output 1: sequencer is in HALTED.

## Operation
- **Registers:**
  - `PC` holds the next fetch address.
  - IF/ID holds `InstrOut`, `PCOut` and `InstrValid`.
  - A one-entry skid buffer holds instruction, PC and valid.
- **FSM states:**
  - `IDLE`: no request outstanding.
  - `WAIT`: live request outstanding.
  - `DRAIN`: squashed request outstanding; has a `HaltAfter` flag.
  - `HALTED`.
- **Issue:**
  - `ImemReq` = (`IDLE`, or `WAIT` with a live `ImemValid` this cycle) and skid empty-after-this-cycle and no redirect/halt this cycle.
  - `ImemAddr` = `PC`. `PC` increments by 1 on issue.
  - At most one request is outstanding.
- **Consume:** IF/ID is consumed when `InstrValid & ~Stall`.
- **Live response:**
  - Loads IF/ID if IF/ID is empty or consumed this cycle.
  - Otherwise loads the skid buffer.
  - Skid contents move to IF/ID before any new response.
- **Jump redirect:** `TakeJump` and `InstrValid` and not `Stall`:
  - The jump instruction is consumed normally.
  - Set `PC` <= `JumpAddress`; flush the skid buffer; clear `InstrValid`.
  - An outstanding request sends the FSM to `DRAIN`, else to `IDLE`.
- **Halt:** `Halt` and `InstrValid` and not `Stall`:
  - The halt instruction is consumed.
  - Flush as for a jump.
  - Go to `HALTED`, or to `DRAIN` with `HaltAfter` = 1 if a request is outstanding.
- **Branch redirect:** `BranchTaken` overrides jump and halt in the same cycle.
  - Set `PC` <= `BranchTarget`; clear IF/ID and skid regardless of `Stall`.
  - Clear `HaltAfter`.
  - Exits `HALTED`, to `IDLE`.
- **DRAIN:** discards the next `ImemValid`, then goes to `HALTED` if `HaltAfter`, else `IDLE`.
- **`ImemValid` with no outstanding request:** ignored.

## Timing
- **Reset values:**
  - Outputs: `InstrValid`=0, `InstrOut`=0, `PCOut`=0, `ImemReq`=0, `Halted`=0.
  - State: FSM=`IDLE`, `PC`=`ResetVector`, skid empty.
- **First fetch:** first cycle after `Reset` falls: `ImemReq`=1, `ImemAddr`=`ResetVector`.
- **Latency:** `ImemValid` in cycle N gives `InstrValid`=1 in N+1.
- **Throughput:** with 1-cycle memory, one instruction per cycle in steady state.
- **Jump bubble:**
  - Redirect in cycle N issues to the target in N+1 if nothing is outstanding.
  - Otherwise it issues in the cycle after the squashed response is discarded.
- **`Stall`:**
  - `Stall` blocks redirect/halt action; jump and halt are taken only when the instruction is consumed.
  - Under continuous `Stall`: at most one response lands in the skid, then issue stops.
- **`Reset` during `WAIT`/`DRAIN`:**
  - The state returns to reset values.
  - A response arriving after `Reset` falls, before the new request, is ignored per the no-outstanding rule.
  - Memory is required to cancel in-flight reads on `Reset`.

## Structure
- Shared package (`cpu_pkg`) holds:
  - `RegWidth`.
  - The HALT encoding 16'h0000.
  - The FSM state enum `fetch_state_t`.
- Sub-module `fetch_skid_buffer`: one-entry buffer with instruction and PC, plus `load`, `unload` and `flush`.
- Jump decode stays outside this block and is connected in the IF-stage top.

## Test plan
- **Reset then 1-cycle memory returning `ImemData`=addr+16'h9010:**
  - `ImemAddr` sequence 0,1,2,3 on consecutive cycles.
  - `InstrValid` continuous from cycle 2, `PCOut` 0,1,2,3.
- **Jump at `PCOut`=8, `JumpAddress`=16'h0020:**
  - The PC 9 response is dropped.
  - Next `ImemAddr`=16'h0020, next `PCOut` after 8 is 16'h0020.
- **`Stall` for 4 cycles with `PCOut`=5:**
  - `InstrOut` and `PCOut` hold; skid holds PC 6; no further `ImemReq`.
  - After release, `PCOut` runs 6,7 with no gaps or duplicates.
- **Halt word 16'h0000 at `PCOut`=3 with a request outstanding:**
  - The response is discarded, `Halted`=1, `ImemReq` stays 0 for 20 cycles.
  - Then `BranchTaken` with `BranchTarget`=16'h0040 gives `Halted`=0, next `ImemAddr`=16'h0040.
- **`BranchTaken` and `TakeJump` asserted in the same cycle:**
  - `BranchTarget` wins, IF/ID is flushed even with `Stall`=1.
- **3-cycle memory latency with `Reset` asserted mid-`WAIT`:**
  - Outputs return to reset values.
  - Fetch restarts at `ResetVector`, and the stale `ImemValid` never appears in `InstrOut`.
